// File: rtl/dm_wbuf.sv
// dm_wbuf: data memory fronted by a small write buffer.
// Writes are queued in a FIFO and drained into DM_data on idle cycles (or
// on a write to a full buffer); reads forward from the youngest matching
// buffered entry so the buffer is invisible to the CPU.
// Optional feature: define DM_ACCESS_CNT_EN to add the wr_cnt/full_cnt
// saturating access counters.
module dm_wbuf #(
    parameter int unsigned bit_size = 32,
    parameter int unsigned mem_size = 16,
    parameter int unsigned DM_WORDS = 256,
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [mem_size-1:0]             DM_Address,
    input  logic                            DM_enable,
    input  logic [bit_size-1:0]             DM_Write_Data,
    output logic [bit_size-1:0]             DM_Read_Data,
    output logic [$clog2(WB_DEPTH+1)-1:0]   wb_count,
    output logic                            wb_full
`ifdef DM_ACCESS_CNT_EN
    ,
    output logic [15:0]                     wr_cnt,
    output logic [15:0]                     full_cnt
`endif
);

    localparam int unsigned IdxW = $clog2(DM_WORDS);
    localparam int unsigned PtrW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(WB_DEPTH + 1);

    // Backing storage; the name is fixed so the bench can inspect it.
    logic [bit_size-1:0] DM_data [0:DM_WORDS-1];

    logic [IdxW-1:0]     wb_idx_q  [WB_DEPTH];
    logic [IdxW-1:0]     wb_idx_d  [WB_DEPTH];
    logic [bit_size-1:0] wb_data_q [WB_DEPTH];
    logic [bit_size-1:0] wb_data_d [WB_DEPTH];
    logic [PtrW-1:0]     head_q, head_d;
    logic [PtrW-1:0]     tail_q, tail_d;
    logic [CntW-1:0]     count_q, count_d;
    logic                full_q, full_d;

    logic                push, pop;
    logic [IdxW-1:0]     wr_idx, rd_idx;
    logic [IdxW-1:0]     drain_idx;
    logic [bit_size-1:0] drain_data;

    // Upper address bits do not select storage.
    logic unused_addr_hi;
    assign unused_addr_hi = ^DM_Address[mem_size-1:IdxW];

    assign wr_idx = DM_Address[IdxW-1:0];
    assign rd_idx = DM_Address[IdxW-1:0];

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // FIFO next state: push on every write, pop on idle cycles or to make room when full.
    always_comb begin
        push      = DM_enable;
        pop       = (count_q != '0) && (!DM_enable || (count_q == CntW'(WB_DEPTH)));
        wb_idx_d  = wb_idx_q;
        wb_data_d = wb_data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (push) begin
            wb_idx_d[tail_q]  = wr_idx;
            wb_data_d[tail_q] = DM_Write_Data;
            tail_d            = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        full_d     = (count_d == CntW'(WB_DEPTH));
        drain_idx  = wb_idx_q[head_q];
        drain_data = wb_data_q[head_q];
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(WB_DEPTH); i++) begin
                wb_idx_q[i]  <= '0;
                wb_data_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            wb_idx_q  <= wb_idx_d;
            wb_data_q <= wb_data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            full_q    <= full_d;
        end
    end

    // Storage array: cleared on reset, written by the draining head entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DM_WORDS); i++) begin
                DM_data[i] <= '0;
            end
        end else if (pop) begin
            DM_data[drain_idx] <= drain_data;
        end
    end

    // Read path: walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        int unsigned     p;
        logic [PtrW-1:0] pos;
        p            = 0;
        pos          = '0;
        DM_Read_Data = DM_data[rd_idx];
        for (int k = 0; k < int'(WB_DEPTH); k++) begin
            p = int'(head_q) + k;
            if (p >= WB_DEPTH) begin
                p = p - WB_DEPTH;
            end
            pos = PtrW'(p);
            if ((CntW'(k) < count_q) && (wb_idx_q[pos] == rd_idx)) begin
                DM_Read_Data = wb_data_q[pos];
            end
        end
    end

    assign wb_count = count_q;
    assign wb_full  = full_q;

`ifdef DM_ACCESS_CNT_EN
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] full_cnt_q, full_cnt_d;

    // Saturating counters of accepted writes and of writes that hit a full buffer.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        full_cnt_d = full_cnt_q;
        if (DM_enable && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_d = wr_cnt_q + 16'd1;
        end
        if (DM_enable && full_q && (full_cnt_q != 16'hFFFF)) begin
            full_cnt_d = full_cnt_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q   <= '0;
            full_cnt_q <= '0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            full_cnt_q <= full_cnt_d;
        end
    end

    assign wr_cnt   = wr_cnt_q;
    assign full_cnt = full_cnt_q;
`endif

endmodule

// File: tb/tb_dm_wbuf.sv
// Testbench for dm_wbuf: directed vector table, reset corner case and a
// randomized run against a queue-based reference model.
module tb_dm_wbuf;

    logic        clk;
    logic        rst;
    logic [15:0] DM_Address;
    logic        DM_enable;
    logic [31:0] DM_Write_Data;
    logic [31:0] DM_Read_Data;
    logic [2:0]  wb_count;
    logic        wb_full;
`ifdef DM_ACCESS_CNT_EN
    logic [15:0] wr_cnt;
    logic [15:0] full_cnt;
`endif

    dm_wbuf dut (
        .clk          (clk),
        .rst          (rst),
        .DM_Address   (DM_Address),
        .DM_enable    (DM_enable),
        .DM_Write_Data(DM_Write_Data),
        .DM_Read_Data (DM_Read_Data),
        .wb_count     (wb_count),
        .wb_full      (wb_full)
`ifdef DM_ACCESS_CNT_EN
        ,
        .wr_cnt       (wr_cnt),
        .full_cnt     (full_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: ordered queue of pending writes plus a flat memory.
    typedef struct {
        logic [7:0]  idx;
        logic [31:0] data;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] mmem [256];

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 256; i++) mmem[i] = '0;
    endtask

    task automatic model_edge(input bit en, input logic [15:0] addr, input logic [31:0] data);
        ent_t e;
        if (en) begin
            if (mq.size() == 4) begin
                e = mq.pop_front();
                mmem[e.idx] = e.data;
            end
            e.idx  = addr[7:0];
            e.data = data;
            mq.push_back(e);
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            mmem[e.idx] = e.data;
        end
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] addr);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].idx == addr[7:0]) return mq[i].data;
        end
        return mmem[addr[7:0]];
    endfunction

    // One clock: drive inputs away from the edge, clock, then sample #1 later.
    task automatic step(input bit en, input logic [15:0] addr, input logic [31:0] data);
        DM_enable     = en;
        DM_Address    = addr;
        DM_Write_Data = data;
        @(posedge clk);
        model_edge(en, addr, data);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit          en;
        logic [15:0] addr;
        logic [31:0] data;
        logic [31:0] rd;
        logic [2:0]  cnt;
        bit          full;
    } vec_t;
    vec_t vecs[19];

    logic [15:0] ra;
    logic [31:0] rdat;
    bit          ren;
`ifdef DM_ACCESS_CNT_EN
    logic [15:0] wr0, fc0;
`endif

    initial begin
        rst           = 1'b1;
        DM_enable     = 1'b0;
        DM_Address    = '0;
        DM_Write_Data = '0;
        model_reset();

        // idle read after reset
        vecs[0]  = '{1'b0, 16'd5, 32'h0, 32'h0, 3'd0, 1'b0};
        // single write, forwarded, then drained
        vecs[1]  = '{1'b1, 16'd3, 32'h12345678, 32'h12345678, 3'd1, 1'b0};
        vecs[2]  = '{1'b0, 16'd3, 32'h0, 32'h12345678, 3'd0, 1'b0};
        // six back-to-back writes; buffer saturates at 4
        vecs[3]  = '{1'b1, 16'd0, 32'd1, 32'd1, 3'd1, 1'b0};
        vecs[4]  = '{1'b1, 16'd1, 32'd2, 32'd2, 3'd2, 1'b0};
        vecs[5]  = '{1'b1, 16'd2, 32'd3, 32'd3, 3'd3, 1'b0};
        vecs[6]  = '{1'b1, 16'd3, 32'd4, 32'd4, 3'd4, 1'b1};
        vecs[7]  = '{1'b1, 16'd4, 32'd5, 32'd5, 3'd4, 1'b1};
        vecs[8]  = '{1'b1, 16'd5, 32'd6, 32'd6, 3'd4, 1'b1};
        vecs[9]  = '{1'b0, 16'd2, 32'h0, 32'd3, 3'd3, 1'b0};
        vecs[10] = '{1'b0, 16'd3, 32'h0, 32'd4, 3'd2, 1'b0};
        vecs[11] = '{1'b0, 16'd4, 32'h0, 32'd5, 3'd1, 1'b0};
        vecs[12] = '{1'b0, 16'd5, 32'h0, 32'd6, 3'd0, 1'b0};
        // same-index writes: younger value wins while buffered and after drain
        vecs[13] = '{1'b1, 16'd9, 32'hA, 32'hA, 3'd1, 1'b0};
        vecs[14] = '{1'b1, 16'd9, 32'hB, 32'hB, 3'd2, 1'b0};
        vecs[15] = '{1'b0, 16'd9, 32'h0, 32'hB, 3'd1, 1'b0};
        vecs[16] = '{1'b0, 16'd9, 32'h0, 32'hB, 3'd0, 1'b0};
        vecs[17] = '{1'b0, 16'd9, 32'h0, 32'hB, 3'd0, 1'b0};
        // upper address bits are ignored (0x0103 -> index 3, last written 4)
        vecs[18] = '{1'b0, 16'h0103, 32'h0, 32'd4, 3'd0, 1'b0};

        do_reset();

        for (int i = 0; i < 19; i++) begin
`ifdef DM_ACCESS_CNT_EN
            if (i == 3) begin
                wr0 = wr_cnt;
                fc0 = full_cnt;
            end
`endif
            step(vecs[i].en, vecs[i].addr, vecs[i].data);
            check($sformatf("vec%0d rd", i), DM_Read_Data, vecs[i].rd);
            check($sformatf("vec%0d cnt", i), 32'(wb_count), 32'(vecs[i].cnt));
            check($sformatf("vec%0d full", i), 32'(wb_full), 32'(vecs[i].full));
            if (i == 2) check("mem3 after drain", dut.DM_data[3], 32'h12345678);
            if (i == 12) begin
                for (int j = 0; j < 6; j++)
                    check($sformatf("mem%0d after burst", j), dut.DM_data[j], 32'(j + 1));
            end
            if (i == 17) check("mem9 final", dut.DM_data[9], 32'hB);
`ifdef DM_ACCESS_CNT_EN
            if (i == 8) begin
                check("wr_cnt burst", 32'(wr_cnt - wr0), 32'd6);
                check("full_cnt burst", 32'(full_cnt - fc0), 32'd2);
            end
`endif
        end

        // Asynchronous reset in the middle of buffered writes.
        step(1'b1, 16'd20, 32'hDEAD0020);
        step(1'b1, 16'd21, 32'hDEAD0021);
        step(1'b1, 16'd22, 32'hDEAD0022);
        check("pre-reset cnt", 32'(wb_count), 32'd3);
        DM_enable = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("async rst cnt", 32'(wb_count), 32'd0);
        check("async rst full", 32'(wb_full), 32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        for (int j = 20; j < 23; j++) begin
            DM_Address = 16'(j);
            #1;
            check($sformatf("rst rd%0d", j), DM_Read_Data, 32'h0);
            check($sformatf("rst mem%0d", j), dut.DM_data[j], 32'h0);
        end
        DM_Address = 16'd3;
        #1;
        check("rst rd3", DM_Read_Data, 32'h0);
        step(1'b0, 16'd21, 32'h0);
        check("rst idle rd21", DM_Read_Data, 32'h0);
        check("rst idle cnt", 32'(wb_count), 32'd0);

        // Randomized traffic on a small index window to provoke aliasing.
        for (int n = 0; n < 400; n++) begin
            ren  = ($urandom_range(0, 99) < 60);
            ra   = {8'($urandom), 5'd0, 3'($urandom)};
            rdat = $urandom;
            step(ren, ra, rdat);
            check($sformatf("rnd%0d cnt", n), 32'(wb_count), 32'(mq.size()));
            check($sformatf("rnd%0d full", n), 32'(wb_full), 32'(mq.size() == 4));
            check($sformatf("rnd%0d rd", n), DM_Read_Data, model_read(ra));
            // also probe a different address combinationally
            DM_Address = {8'($urandom), 5'd0, 3'($urandom)};
            #1;
            check($sformatf("rnd%0d probe", n), DM_Read_Data, model_read(DM_Address));
        end
        for (int n = 0; n < 5; n++) step(1'b0, 16'd0, 32'h0);
        check("rnd drained cnt", 32'(wb_count), 32'd0);
        for (int j = 0; j < 8; j++)
            check($sformatf("rnd mem%0d", j), dut.DM_data[j], mmem[j]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dm_wbuf.md
DM_WBUF -- requirements
Module: dm_wbuf

Interface
REQ-001 Parameter bit_size, default 32, data word width.
REQ-002 Parameter mem_size, default 16, address width.
REQ-003 Parameter DM_WORDS, default 256, storage words; index = DM_Address[7:0], upper bits ignored.
REQ-004 Parameter WB_DEPTH, default 4, write-buffer entries.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 DM_Address  input  16  word address from CPU.
REQ-008 DM_enable  input  1  1 = write request this cycle, 0 = read.
REQ-009 DM_Write_Data  input  32  write data.
REQ-010 DM_Read_Data  output  32  read data.
REQ-011 wb_count  output  3  entries currently buffered, 0..4.
REQ-012 wb_full  output  1  wb_count == WB_DEPTH.
REQ-013 Storage array SHALL be named DM_data[0:DM_WORDS-1], 32 bits each, for hierarchical inspection by the bench.

Function
REQ-014 Each write (DM_enable=1) SHALL enqueue {index, data} at the FIFO tail on that rising edge; no write is ever dropped.
REQ-015 Drain: on any edge with DM_enable=0 and wb_count>0, the head entry SHALL be written into DM_data and popped (one entry per cycle).
REQ-016 Write while not full: enqueue only, no drain; wb_count increments by 1.
REQ-017 Write while full: head SHALL drain into DM_data and new entry enqueue on the same edge; wb_count stays 4.
REQ-018 FIFO order SHALL be preserved; two buffered writes to the same index both drain, older first, so the younger value ends in DM_data.
REQ-019 DM_Read_Data SHALL be combinational: data of the youngest buffered entry whose index matches DM_Address[7:0], else DM_data[index].
REQ-020 A write on edge N SHALL be visible on DM_Read_Data from immediately after edge N (forwarded from the buffer).
REQ-021 Entry drained on edge N and read at same index after edge N SHALL return the array value, identical to the forwarded value.
REQ-022 wb_count/wb_full SHALL be registered outputs updating on the same edge as the FIFO.
REQ-023 Head/tail pointers SHALL wrap modulo WB_DEPTH.

Reset
REQ-024 rst=1 SHALL asynchronously empty the FIFO (wb_count=0, wb_full=0, pointers 0) and clear all DM_data words to 0.
REQ-025 Reset mid-operation SHALL discard buffered undrained writes; DM_Read_Data then returns 0 for every index.
REQ-026 Counters (REQ-027) SHALL reset to 0.

Configuration
REQ-027 Macro DM_ACCESS_CNT_EN defined: add outputs wr_cnt[15:0] (accepted writes) and full_cnt[15:0] (writes arriving while wb_full=1), both saturating at 16'hFFFF.
REQ-028 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-029 Reset, then read index 5 -> DM_Read_Data=0, wb_count=0, wb_full=0.
REQ-030 Write idx3=32'h12345678 one cycle, then reads -> data visible immediately, wb_count 1 then 0, DM_data[3]=32'h12345678 after one idle cycle.
REQ-031 Six back-to-back writes idx0..5 = 1..6 -> wb_full after 4th, wb_count stays 4, after 4 idle cycles DM_data[0..5]=1..6, wb_count=0.
REQ-032 Writes idx9=32'hA then idx9=32'hB back-to-back, read idx9 -> 32'hB while buffered and after full drain.
REQ-033 Three writes buffered, rst pulsed mid-stream -> wb_count=0, DM_data[written idx]=0, reads return 0.
REQ-034 With DM_ACCESS_CNT_EN, scenario REQ-031 -> wr_cnt=6, full_cnt=2.
